sseg_capture: RTL and testbench
===============================

# sseg_capture

Receive-side decoder for the multiplexed seven-segment bus produced by the display driver. It samples the active-low segment and anode lines and waits for each digit slot to settle. It then decodes each segment pattern back into a 4-bit value and holds four digit registers (ones, tens, hundreds, thousands). It sits in the self-check and loopback path, where it lets the counter/display chain be verified end to end from the physical display pins.

## Interface
- `SETTLE`, default 8: number of consecutive identical synchronized samples required before a capture; legal range 2–255.
- `TIMEOUT`, default 100000: number of cycles without a capture before `live` drops; must be at least 2.
- `clk`, input, 1: system clock; all logic runs on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `sseg`, input, 7: segment cathodes, active-low; bit 0 = a … bit 6 = g. Asynchronous to `clk`.
- `AN`, input, 8: digit anodes, active-low; `AN[0]` = ones … `AN[3]` = thousands. Asynchronous to `clk`.
- `ones`, `tens`, `hundreds`, `thousands`, output, 4 each: last successfully decoded value per digit.
- `err`, output, 4: per-digit flag, bit order as `AN[3:0]`; set when the last capture for that digit held an undecodable pattern.
- `frame_valid`, output, 1: one-cycle pulse when all four digits have been captured since the previous pulse.
- `live`, output, 1: high while captures keep arriving within `TIMEOUT`.

## Operation
- **Input sync:** `sseg` and `AN` each pass through a 2-flop synchronizer. Reset value of both stages is all-ones, which reads as blank and no anode selected.
- **Valid slot:** exactly one of the synchronized `AN[3:0]` is 0 and `AN[7:4]` is 4'hF. Any other anode state counts as blanking: the stability counter clears and nothing is captured. `AN[7:4]` activity is never captured.
- **Stability counter:**
  - If the synchronized {AN, sseg} pair matches the previous cycle's pair and the slot is valid, the counter increments, saturating at `SETTLE`.
  - On any change the counter loads 1 if the new slot is valid, otherwise 0.
  - A capture fires on the edge where the counter reaches `SETTLE`, so there is exactly one capture per stable window. A held pair never recaptures.
- **Decode** (active-high gfedcba, i.e. `~sseg`): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9. Hex letters are decoded only as described under Configuration.
- **On a valid decode:** write the selected digit register and clear its `err` bit.
- **On an undecodable pattern** (including blank 00): the digit register holds its previous value and its `err` bit is set.
- **Frame mask:** 4 bits. Any capture, valid or not, sets the selected digit's mask bit.
  - When a capture makes the mask 4'hF, `frame_valid` is 1 for the following cycle and the mask clears on that same capture edge.
  - Recapturing an already-masked digit overwrites that digit and leaves the mask unchanged.
- **`live`:** set by any capture. A timeout counter reloads on each capture; `live` clears when `TIMEOUT` cycles elapse with no capture.
- **Reset values:** all digits 0, `err` 0, `frame_valid` 0, `live` 0, mask 0, stability and timeout counters 0. Reset asserted mid-window discards the partial window; after release, a full `SETTLE` window is needed again.

## Timing
- **Capture latency:** if the inputs change before rising edge k and then stay stable, the digit, `err` and mask update on edge k+`SETTLE`+1. `frame_valid` is high during the cycle after that edge.
- **Minimum digit dwell:** `SETTLE`+2 clock cycles. Shorter slots are ignored.
- **Glitches:** a one-cycle glitch inside a window restarts the count. No capture occurs until the pair has been stable for `SETTLE` samples again.
- **Simultaneous events:** on the timeout-expiry edge, a capture wins — `live` stays 1 and the timeout counter reloads.
- **Outputs** are registered, with no combinational path from the inputs.

## Configuration
- Macro `SSEG_CAPTURE_HEX_EN`.
- **Defined:** additionally decodes 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F to values 10–15.
- **Undefined:** those six patterns are undecodable. They set `err` and leave the digit register unchanged.

## Test plan
- Reset, then hold `AN`=8'hFE with `sseg`=7'h40 (digit "0") for `SETTLE`+2 cycles → `ones`=0, `err`=0, `live`=1, `frame_valid`=0.
- Scan AN FE/FD/FB/F7 with patterns for 4/2/9/1 (`sseg` 19/24/10/79), 16 cycles per slot → `ones`=4, `tens`=2, `hundreds`=9, `thousands`=1, exactly one `frame_valid` pulse per full scan.
- Hold `AN`=8'hFD with `sseg` toggling every `SETTLE`−1 cycles → `tens` never changes and no capture occurs.
- Drive `AN`=8'hFB with `sseg`=7'h08 (pattern "A"):
  - With `SSEG_CAPTURE_HEX_EN` defined → `hundreds`=10, `err[2]`=0.
  - With it undefined → `hundreds` keeps its old value, `err[2]`=1.
- Drive `AN`=8'hFC (two anodes low) or `AN`=8'hEF → no capture; after `TIMEOUT` idle cycles → `live`=0.
- Assert `reset` at counter value `SETTLE`−1 mid-window → all outputs 0; a capture occurs only after a fresh `SETTLE`-sample window following release.

Source files
------------

// File: rtl/sseg_capture.sv
// Receive-side decoder for a multiplexed active-low seven-segment bus: recovers four digit values.
// Optional hex-letter decoding is enabled by defining SSEG_CAPTURE_HEX_EN.
module sseg_capture #(
  parameter int unsigned SETTLE  = 8,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] sseg,
  input  logic [7:0] AN,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [3:0] hundreds,
  output logic [3:0] thousands,
  output logic [3:0] err,
  output logic       frame_valid,
  output logic       live
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0]    SETTLE_M1 = 8'(SETTLE - 1);
  localparam logic [7:0]    SETTLE_V  = 8'(SETTLE);
  localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT);

  logic [6:0]    sseg_s1, sseg_s2, sseg_p;
  logic [7:0]    an_s1, an_s2, an_p;
  logic [7:0]    cnt;
  logic [TW-1:0] tcnt;
  logic [3:0]    mask;

  logic       same, slot_ok, capture, dec_ok;
  logic [1:0] idx;
  logic [3:0] dec_val, mask_next;

  function automatic logic [4:0] decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h3F: r = {1'b1, 4'd0};
      7'h06: r = {1'b1, 4'd1};
      7'h5B: r = {1'b1, 4'd2};
      7'h4F: r = {1'b1, 4'd3};
      7'h66: r = {1'b1, 4'd4};
      7'h6D: r = {1'b1, 4'd5};
      7'h7D: r = {1'b1, 4'd6};
      7'h07: r = {1'b1, 4'd7};
      7'h7F: r = {1'b1, 4'd8};
      7'h6F: r = {1'b1, 4'd9};
`ifdef SSEG_CAPTURE_HEX_EN
      7'h77: r = {1'b1, 4'd10};
      7'h7C: r = {1'b1, 4'd11};
      7'h39: r = {1'b1, 4'd12};
      7'h5E: r = {1'b1, 4'd13};
      7'h79: r = {1'b1, 4'd14};
      7'h71: r = {1'b1, 4'd15};
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    same    = (an_s2 == an_p) && (sseg_s2 == sseg_p);
    slot_ok = 1'b1;
    idx     = 2'd0;
    case (an_s2[3:0])
      4'hE:    idx = 2'd0;
      4'hD:    idx = 2'd1;
      4'hB:    idx = 2'd2;
      4'h7:    idx = 2'd3;
      default: slot_ok = 1'b0;
    endcase
    if (an_s2[7:4] != 4'hF) slot_ok = 1'b0;
    // Fires only on the increment into SETTLE, so a held pair captures once.
    capture   = same && slot_ok && (cnt == SETTLE_M1);
    {dec_ok, dec_val} = decode(~sseg_s2);
    mask_next = mask | (4'b0001 << idx);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sseg_s1     <= '1;
      sseg_s2     <= '1;
      sseg_p      <= '1;
      an_s1       <= '1;
      an_s2       <= '1;
      an_p        <= '1;
      cnt         <= '0;
      tcnt        <= '0;
      mask        <= '0;
      ones        <= '0;
      tens        <= '0;
      hundreds    <= '0;
      thousands   <= '0;
      err         <= '0;
      frame_valid <= 1'b0;
      live        <= 1'b0;
    end else begin
      sseg_s1     <= sseg;
      sseg_s2     <= sseg_s1;
      an_s1       <= AN;
      an_s2       <= an_s1;
      sseg_p      <= sseg_s2;
      an_p        <= an_s2;
      frame_valid <= 1'b0;

      if (!slot_ok)            cnt <= '0;
      else if (!same)          cnt <= 8'd1;
      else if (cnt != SETTLE_V) cnt <= cnt + 8'd1;

      if (capture) begin
        if (dec_ok) begin
          case (idx)
            2'd0: ones      <= dec_val;
            2'd1: tens      <= dec_val;
            2'd2: hundreds  <= dec_val;
            default: thousands <= dec_val;
          endcase
        end
        err[idx] <= ~dec_ok;
        if (mask_next == 4'hF) begin
          mask        <= '0;
          frame_valid <= 1'b1;
        end else begin
          mask <= mask_next;
        end
        live <= 1'b1;
        tcnt <= TIMEOUT_V;
      end else if (tcnt != '0) begin
        tcnt <= tcnt - TW'(1);
        if (tcnt == TW'(1)) live <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sseg_capture.sv
// Bench for sseg_capture: directed vectors, frame scoreboard plus direct register checks.
module tb_sseg_capture;

  localparam int unsigned SETTLE  = 4;
  localparam int unsigned TIMEOUT = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] sseg = '1;
  logic [7:0] AN = '1;
  logic [3:0] ones, tens, hundreds, thousands, err;
  logic       frame_valid, live;

  int total = 0;
  int bad   = 0;

  // expected frame: {thousands, hundreds, tens, ones, err}
  logic [19:0] exp_q[$];

  sseg_capture #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .sseg(sseg), .AN(AN),
    .ones(ones), .tens(tens), .hundreds(hundreds), .thousands(thousands),
    .err(err), .frame_valid(frame_valid), .live(live)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic slot(input logic [7:0] an, input logic [6:0] seg, input int n);
    AN = an;
    sseg = seg;
    cycles(n);
  endtask

  // Monitor: every frame_valid pulse must match the oldest queued frame.
  always @(negedge clk) begin
    if (!reset && frame_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 32'(frame_valid), 32'd0);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        check("frame_digits", {16'd0, thousands, hundreds, tens, ones}, {16'd0, e[19:4]});
        check("frame_err", 32'(err), 32'(e[3:0]));
      end
    end
  end

  initial begin
    cycles(2);
    check("rst_ones", 32'(ones), 0);
    check("rst_tens", 32'(tens), 0);
    check("rst_hundreds", 32'(hundreds), 0);
    check("rst_thousands", 32'(thousands), 0);
    check("rst_err", 32'(err), 0);
    check("rst_live", 32'(live), 0);
    check("rst_fv", 32'(frame_valid), 0);
    reset = 1'b0;

    // Digit "0" on ones for exactly SETTLE+2 cycles.
    slot(8'hFE, 7'h40, SETTLE + 2);
    check("first_ones", 32'(ones), 0);
    check("first_err", 32'(err), 0);
    check("first_live", 32'(live), 1);
    check("first_fv", 32'(frame_valid), 0);

    // Two full scans showing 1924; one frame each.
    exp_q.push_back({4'd1, 4'd9, 4'd2, 4'd4, 4'h0});
    exp_q.push_back({4'd1, 4'd9, 4'd2, 4'd4, 4'h0});
    for (int s = 0; s < 2; s++) begin
      slot(8'hFE, 7'h19, 16);
      slot(8'hFD, 7'h24, 16);
      slot(8'hFB, 7'h10, 16);
      slot(8'hF7, 7'h79, 16);
    end
    cycles(2);
    check("scan_ones", 32'(ones), 4);
    check("scan_tens", 32'(tens), 2);
    check("scan_hundreds", 32'(hundreds), 9);
    check("scan_thousands", 32'(thousands), 1);
    check("scan_frames_left", 32'(exp_q.size()), 0);

    // Pattern toggling every SETTLE-1 cycles never settles.
    for (int t = 0; t < 10; t++)
      slot(8'hFD, (t % 2 == 0) ? 7'h78 : 7'h00, SETTLE - 1);
    check("toggle_tens", 32'(tens), 2);
    check("toggle_err", 32'(err), 0);
    slot(8'hFF, 7'h7F, 4);

    // Hex letter "A" on hundreds.
    slot(8'hFB, 7'h08, 16);
`ifdef SSEG_CAPTURE_HEX_EN
    check("hex_hundreds", 32'(hundreds), 10);
    check("hex_err", 32'(err), 32'h0);
`else
    check("hex_hundreds", 32'(hundreds), 9);
    check("hex_err", 32'(err), 32'h4);
`endif

    // Illegal anode states: no capture, then live times out.
    slot(8'hFC, 7'h40, 20);
    check("two_an_ones", 32'(ones), 4);
    check("two_an_live", 32'(live), 1);
    slot(8'hEF, 7'h40, TIMEOUT);
    check("upper_an_ones", 32'(ones), 4);
    check("timeout_live", 32'(live), 0);

    // Reset with counter at SETTLE-1, then a fresh window is required.
    slot(8'hF7, 7'h78, 5);
    reset = 1'b1;
    #1;
    check("midrst_thousands", 32'(thousands), 0);
    check("midrst_ones", 32'(ones), 0);
    check("midrst_err", 32'(err), 0);
    check("midrst_live", 32'(live), 0);
    cycles(2);
    reset = 1'b0;
    cycles(SETTLE + 1);
    check("post_rst_early", 32'(thousands), 0);
    cycles(1);
    check("post_rst_capture", 32'(thousands), 7);
    check("post_rst_live", 32'(live), 1);

    // Blank pattern is undecodable.
    slot(8'hFE, 7'h7F, SETTLE + 4);
    check("blank_ones", 32'(ones), 0);
    check("blank_err", 32'(err), 32'h1);

    cycles(3);
    check("frames_left", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
